// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for a streaming FFT core: configures the core, streams N source
// samples through a 2-entry skid buffer, writes N results to the destination RAM.
module fft_frame_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOG2N  = 10,
  parameter int ADDR_WIDTH = MAX_LOG2N
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  ctrl_start,
  input  logic [3:0]            ctrl_log2n,
  input  logic                  ctrl_inverse,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic [1:0]            sts_err,
  output logic [15:0]           sts_frames,
  output logic                  irq,
  output logic                  src_rd_en,
  output logic [ADDR_WIDTH-1:0] src_rd_addr,
  input  logic [DATA_WIDTH-1:0] src_rd_data,
  output logic                  cfg_tvalid,
  input  logic                  cfg_tready,
  output logic [7:0]            cfg_tdata,
  output logic                  s_tvalid,
  input  logic                  s_tready,
  output logic [DATA_WIDTH-1:0] s_tdata,
  output logic                  s_tlast,
  input  logic                  m_tvalid,
  input  logic [DATA_WIDTH-1:0] m_tdata,
  input  logic                  m_tlast,
  output logic                  m_tready,
  output logic                  dst_wr_en,
  output logic [ADDR_WIDTH-1:0] dst_wr_addr,
  output logic [DATA_WIDTH-1:0] dst_wr_data
);
  localparam int CW = MAX_LOG2N + 1;
  localparam logic [3:0] L2_MIN = 4'd3;
  localparam logic [3:0] L2_MAX = 4'(MAX_LOG2N);

  typedef enum logic [2:0] {IDLE, CONFIG, STREAM, DRAIN, DONE} state_t;
  state_t r_state, w_state_nx;

  logic [3:0]            r_log2n;
  logic                  r_inv;
  logic                  r_busy, r_done, r_irq;
  logic [1:0]            r_err;
  logic [15:0]           r_frames;
  logic [CW-1:0]         r_rd_idx, r_in_idx, r_out_idx;
  logic                  r_rd_pend;
  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_buf0, r_buf1;
  logic                  r_fin, r_tl_err;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  logic [CW-1:0] w_n, w_last_idx;
  logic w_legal, w_start_ok, w_start_bad, w_run, w_active, w_fin_go;
  logic w_s_valid, w_s_hs, w_rd_en, w_push, w_m_hs, w_m_at_last;

  assign w_n         = CW'(1) << r_log2n;
  assign w_last_idx  = w_n - CW'(1);
  assign w_legal     = (ctrl_log2n >= L2_MIN) && (ctrl_log2n <= L2_MAX);
  assign w_start_ok  = (r_state == IDLE) && ctrl_start && w_legal;
  assign w_start_bad = (r_state == IDLE) && ctrl_start && !w_legal;
  assign w_run       = (r_state == STREAM) && !r_fin;
  assign w_active    = ((r_state == STREAM) || (r_state == DRAIN)) && !r_fin;
  assign w_fin_go    = ((r_state == STREAM) || (r_state == DRAIN)) && r_fin;

  assign w_s_valid = w_run && (r_occ != 2'd0);
  assign w_s_hs    = w_s_valid && s_tready;
  // Counting the head beat that leaves this cycle keeps the stream gap-free at full rate.
  assign w_rd_en   = w_run && (r_rd_idx < w_n) &&
                     (({1'b0, r_occ} + {2'b00, r_rd_pend}) < (3'd2 + {2'b00, w_s_hs}));
  assign w_push    = w_run && r_rd_pend;

  assign w_m_hs      = m_tvalid && w_active;
  assign w_m_at_last = (r_out_idx == w_last_idx);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_nx = CONFIG;
      CONFIG:  if (cfg_tready) w_state_nx = STREAM;
      STREAM: begin
        if (r_fin)                                 w_state_nx = DONE;
        else if (w_s_hs && r_in_idx == w_last_idx) w_state_nx = DRAIN;
      end
      DRAIN:   if (r_fin) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_log2n   <= '0;
      r_inv     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_irq     <= 1'b0;
      r_err     <= '0;
      r_frames  <= '0;
      r_rd_idx  <= '0;
      r_in_idx  <= '0;
      r_out_idx <= '0;
      r_rd_pend <= 1'b0;
      r_occ     <= '0;
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_fin     <= 1'b0;
      r_tl_err  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_irq     <= w_start_bad || w_fin_go;
      r_rd_pend <= w_rd_en;
      r_wr_en   <= w_m_hs;
      if (w_start_ok) begin
        r_log2n   <= ctrl_log2n;
        r_inv     <= ctrl_inverse;
        r_busy    <= 1'b1;
        r_done    <= 1'b0;
        r_err     <= '0;
        r_rd_idx  <= '0;
        r_in_idx  <= '0;
        r_out_idx <= '0;
        r_occ     <= '0;
        r_fin     <= 1'b0;
        r_tl_err  <= 1'b0;
      end
      if (w_start_bad) r_err <= 2'b01;
      if (w_rd_en) r_rd_idx <= r_rd_idx + CW'(1);
      if (w_s_hs)  r_in_idx <= r_in_idx + CW'(1);
      // Skid buffer: head in r_buf0, second entry in r_buf1.
      if (w_push && w_s_hs) begin
        if (r_occ == 2'd1) r_buf0 <= src_rd_data;
        else begin
          r_buf0 <= r_buf1;
          r_buf1 <= src_rd_data;
        end
      end else if (w_push) begin
        if (r_occ == 2'd0) r_buf0 <= src_rd_data;
        else               r_buf1 <= src_rd_data;
        r_occ <= r_occ + 2'd1;
      end else if (w_s_hs) begin
        r_buf0 <= r_buf1;
        r_occ  <= r_occ - 2'd1;
      end
      if (w_m_hs) begin
        r_out_idx <= r_out_idx + CW'(1);
        r_wr_addr <= r_out_idx[ADDR_WIDTH-1:0];
        r_wr_data <= m_tdata;
        if (w_m_at_last) begin
          r_fin <= 1'b1;
          if (!m_tlast) r_tl_err <= 1'b1;
        end else if (m_tlast) begin
          r_fin    <= 1'b1;
          r_tl_err <= 1'b1;
        end
      end
      // Status commits one cycle after the final write, all together.
      if (w_fin_go) begin
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
        r_err[1] <= r_tl_err;
        r_frames <= r_frames + 16'd1;
      end
    end
  end

  assign sts_busy    = r_busy;
  assign sts_done    = r_done;
  assign sts_err     = r_err;
  assign sts_frames  = r_frames;
  assign irq         = r_irq;
  assign src_rd_en   = w_rd_en;
  assign src_rd_addr = r_rd_idx[ADDR_WIDTH-1:0];
  assign cfg_tvalid  = (r_state == CONFIG);
  assign cfg_tdata   = (r_state == CONFIG) ? {2'b00, ~r_inv, 1'b0, r_log2n} : 8'h00;
  assign s_tvalid    = w_s_valid;
  assign s_tdata     = r_buf0;
  assign s_tlast     = w_s_valid && (r_in_idx == w_last_idx);
  assign m_tready    = w_active;
  assign dst_wr_en   = r_wr_en;
  assign dst_wr_addr = r_wr_addr;
  assign dst_wr_data = r_wr_data;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer: source RAM model, echo core with a
// 4-cycle delay, and per-scenario tasks comparing stream beats, writes and status.
module tb_fft_frame_sequencer;
  localparam int DW = 32;
  localparam int ML = 10;
  localparam int AW = ML;

  bit            ACLK;
  logic          ARESET;
  logic          ctrl_start;
  logic [3:0]    ctrl_log2n;
  logic          ctrl_inverse;
  logic          sts_busy, sts_done, irq;
  logic [1:0]    sts_err;
  logic [15:0]   sts_frames;
  logic          src_rd_en;
  logic [AW-1:0] src_rd_addr;
  logic [DW-1:0] src_rd_data;
  logic          cfg_tvalid;
  bit            cfg_tready;
  logic [7:0]    cfg_tdata;
  logic          s_tvalid, s_tlast;
  bit            s_tready;
  logic [DW-1:0] s_tdata;
  logic          m_tvalid, m_tlast, m_tready;
  logic [DW-1:0] m_tdata;
  logic          dst_wr_en;
  logic [AW-1:0] dst_wr_addr;
  logic [DW-1:0] dst_wr_data;

  fft_frame_sequencer #(.DATA_WIDTH(DW), .MAX_LOG2N(ML)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ctrl_start(ctrl_start), .ctrl_log2n(ctrl_log2n), .ctrl_inverse(ctrl_inverse),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_err(sts_err), .sts_frames(sts_frames),
    .irq(irq),
    .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready), .cfg_tdata(cfg_tdata),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;
  int exp_frames = 0;

  // Environment controls (written only by the test sequence).
  bit bp_mode  = 1'b0;
  int cfg_delay = 0;
  int err_mode  = 0;   // 0 normal, 1 early tlast at index 5, 2 tlast missing

  logic [DW-1:0] mem [0:1023];
  logic [DW:0]      exp_s[$], obs_s[$];
  logic [AW+DW-1:0] exp_w[$], obs_w[$];
  logic [7:0] obs_cfg;
  int cyc = 0, last_wr_cyc = 0, s_first_cyc = 0, s_last_cyc = 0;
  int stab_bad = 0, act_cnt = 0, busy_cnt = 0;

  logic [127:0] all_out;
  assign all_out = 128'({sts_busy, sts_done, sts_err, sts_frames, irq, src_rd_en, src_rd_addr,
                         cfg_tvalid, cfg_tdata, s_tvalid, s_tdata, s_tlast, m_tready,
                         dst_wr_en, dst_wr_addr, dst_wr_data});

  always @(posedge ACLK) cyc <= cyc + 1;

  // Source RAM: one-cycle read latency.
  always @(posedge ACLK) if (src_rd_en) src_rd_data <= mem[src_rd_addr];

  // Echo core: each accepted input reappears on the result stream 4 cycles later.
  bit            dl_v [4];
  bit            dl_l [4];
  logic [DW-1:0] dl_d [4];
  int            out_cnt = 0;
  always @(posedge ACLK) begin
    dl_v[0] <= s_tvalid && s_tready;
    dl_l[0] <= s_tlast;
    dl_d[0] <= s_tdata;
    for (int i = 1; i < 4; i++) begin
      dl_v[i] <= dl_v[i-1];
      dl_l[i] <= dl_l[i-1];
      dl_d[i] <= dl_d[i-1];
    end
    if (ctrl_start)                 out_cnt <= 0;
    else if (m_tvalid && m_tready)  out_cnt <= out_cnt + 1;
  end
  assign m_tvalid = dl_v[3];
  assign m_tdata  = dl_d[3];
  always_comb begin
    m_tlast = dl_l[3];
    if (err_mode == 1)      m_tlast = (out_cnt == 5);
    else if (err_mode == 2) m_tlast = 1'b0;
  end

  // Ready generators, updated just after each rising edge.
  int cfg_cnt = 0;
  always begin
    @(posedge ACLK);
    #1;
    s_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (cfg_tvalid) cfg_cnt = cfg_cnt + 1;
    else            cfg_cnt = 0;
    cfg_tready = cfg_tvalid && (cfg_cnt > cfg_delay);
  end

  // Observation on the falling edge.
  logic          prev_v, prev_r, prev_l;
  logic [DW-1:0] prev_d;
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (s_tvalid && s_tready) begin
        if (obs_s.size() == 0) s_first_cyc = cyc;
        s_last_cyc = cyc;
        obs_s.push_back({s_tlast, s_tdata});
      end
      if (dst_wr_en) begin
        obs_w.push_back({dst_wr_addr, dst_wr_data});
        last_wr_cyc = cyc;
      end
      if (cfg_tvalid && cfg_tready) obs_cfg = cfg_tdata;
      if (prev_v && !prev_r && (!s_tvalid || s_tdata !== prev_d || s_tlast !== prev_l))
        stab_bad = stab_bad + 1;
      if (src_rd_en || s_tvalid || cfg_tvalid || dst_wr_en || m_tready) act_cnt = act_cnt + 1;
      if (sts_busy) busy_cnt = busy_cnt + 1;
    end
    prev_v = s_tvalid;
    prev_r = s_tready;
    prev_d = s_tdata;
    prev_l = s_tlast;
  end

  task automatic run_frame(input int l2n, input bit inv, input bit bp, input int cdly,
                           input int emode, input bit extra_start, input int base);
    int n, nw, st0, xs, irq_cyc;
    bit seen;
    logic [7:0] exp_cfg;
    logic [DW:0] es, os;
    logic [AW+DW-1:0] ew, ow;
    n = 1 << l2n;
    nw = (emode == 1) ? 6 : n;
    exp_cfg = {2'b00, ~inv, 1'b0, 4'(l2n)};
    obs_s.delete(); obs_w.delete(); exp_s.delete(); exp_w.delete();
    for (int i = 0; i < n; i++) begin
      mem[i] = DW'(base + i);
      exp_s.push_back({(i == n - 1), DW'(base + i)});
    end
    for (int i = 0; i < nw; i++) exp_w.push_back({AW'(i), DW'(base + i)});
    bp_mode = bp; cfg_delay = cdly; err_mode = emode;
    st0 = stab_bad;
    @(posedge ACLK); #1;
    ctrl_log2n = 4'(l2n); ctrl_inverse = inv; ctrl_start = 1'b1;
    @(posedge ACLK); #1;
    ctrl_start = 1'b0;
    total++;
    if (sts_busy !== 1'b1 || cfg_tvalid !== 1'b1) begin
      bad++; $display("FAIL start_latency: busy=%b cfg_tvalid=%b want 1/1", sts_busy, cfg_tvalid);
    end
    seen = 0; xs = 0; irq_cyc = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(posedge ACLK); #1;
      if (xs == 1) begin ctrl_start = 1'b0; xs = 2; end
      else if (extra_start && xs == 0 && s_tvalid) begin ctrl_start = 1'b1; xs = 1; end
      if (irq) begin seen = 1; irq_cyc = cyc; end
    end
    ctrl_start = 1'b0;
    total++;
    if (!seen) begin bad++; $display("FAIL frame_timeout: no irq within budget l2n=%0d", l2n); end
    exp_frames++;
    total++;
    if (sts_done !== 1'b1 || sts_busy !== 1'b0) begin
      bad++; $display("FAIL end_status: done=%b busy=%b want 1/0", sts_done, sts_busy);
    end
    total++;
    if (sts_err !== ((emode != 0) ? 2'b10 : 2'b00)) begin
      bad++; $display("FAIL end_err: got %b want %b", sts_err, (emode != 0) ? 2'b10 : 2'b00);
    end
    total++;
    if (sts_frames !== 16'(exp_frames)) begin
      bad++; $display("FAIL frames: got %0d want %0d", sts_frames, exp_frames);
    end
    total++;
    if (irq_cyc !== last_wr_cyc + 1) begin
      bad++; $display("FAIL irq_timing: irq cycle %0d want %0d", irq_cyc, last_wr_cyc + 1);
    end
    total++;
    if (obs_cfg !== exp_cfg) begin
      bad++; $display("FAIL cfg_tdata: got %h want %h", obs_cfg, exp_cfg);
    end
    if (emode != 1) begin
      total++;
      if (obs_s.size() != n) begin
        bad++; $display("FAIL s_count: got %0d want %0d", obs_s.size(), n);
      end
      while (exp_s.size() > 0 && obs_s.size() > 0) begin
        es = exp_s.pop_front(); os = obs_s.pop_front();
        total++;
        if (os !== es) begin bad++; $display("FAIL s_beat: got %h want %h", os, es); end
      end
      if (!bp) begin
        total++;
        if (s_last_cyc - s_first_cyc != n - 1) begin
          bad++; $display("FAIL s_bubbles: span %0d want %0d", s_last_cyc - s_first_cyc, n - 1);
        end
      end
    end
    if (bp) begin
      total++;
      if (stab_bad != st0) begin
        bad++; $display("FAIL s_stable: %0d changes while stalled, want 0", stab_bad - st0);
      end
    end
    total++;
    if (obs_w.size() != nw) begin
      bad++; $display("FAIL wr_count: got %0d want %0d", obs_w.size(), nw);
    end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      ew = exp_w.pop_front(); ow = obs_w.pop_front();
      total++;
      if (ow !== ew) begin bad++; $display("FAIL dst_write: got %h want %h", ow, ew); end
    end
    bp_mode = 1'b0; cfg_delay = 0; err_mode = 0;
  endtask

  task automatic test_reset;
    ARESET = 1'b1; ctrl_start = 1'b0; ctrl_log2n = 4'd0; ctrl_inverse = 1'b0;
    #2;
    total++;
    if (all_out !== 128'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    @(posedge ACLK); @(posedge ACLK); #1;
    total++;
    if (all_out !== 128'd0) begin bad++; $display("FAIL reset_hold: got %h want 0", all_out); end
    ARESET = 1'b0;
    repeat (3) @(posedge ACLK);
  endtask

  task automatic test_nominal;
    run_frame(3, 1'b0, 1'b0, 0, 0, 1'b0, 1);
    @(posedge ACLK); #1;
    total++;
    if (irq !== 1'b0 || sts_done !== 1'b1) begin
      bad++; $display("FAIL irq_pulse: irq=%b done=%b want 0/1", irq, sts_done);
    end
  endtask

  task automatic test_backpressure;
    run_frame(4, 1'b0, 1'b1, 5, 0, 1'b0, 1);
  endtask

  task automatic test_illegal(input int l2n);
    int irqs, a0, b0;
    logic [15:0] f0;
    logic d0;
    a0 = act_cnt; b0 = busy_cnt; f0 = sts_frames; d0 = sts_done;
    @(posedge ACLK); #1;
    ctrl_log2n = 4'(l2n); ctrl_start = 1'b1;
    @(posedge ACLK); #1;
    ctrl_start = 1'b0;
    irqs = irq ? 1 : 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge ACLK); #1;
      if (irq) irqs++;
    end
    total++;
    if (sts_err !== 2'b01) begin bad++; $display("FAIL illegal_err l2n=%0d: got %b want 01", l2n, sts_err); end
    total++;
    if (irqs != 1) begin bad++; $display("FAIL illegal_irq l2n=%0d: got %0d pulses want 1", l2n, irqs); end
    total++;
    if (busy_cnt != b0 || act_cnt != a0) begin
      bad++; $display("FAIL illegal_activity l2n=%0d: busy %0d act %0d want 0/0", l2n, busy_cnt - b0, act_cnt - a0);
    end
    total++;
    if (sts_frames !== f0 || sts_done !== d0) begin
      bad++; $display("FAIL illegal_status l2n=%0d: frames %0d done %b want %0d %b", l2n, sts_frames, sts_done, f0, d0);
    end
  endtask

  task automatic test_tlast_errors;
    run_frame(3, 1'b0, 1'b0, 0, 1, 1'b0, 40);
    repeat (8) @(posedge ACLK);
    run_frame(3, 1'b1, 1'b0, 0, 2, 1'b0, 60);
  endtask

  task automatic test_busy_start;
    run_frame(3, 1'b0, 1'b0, 0, 0, 1'b1, 80);
  endtask

  task automatic test_back_to_back;
    run_frame(3, 1'b0, 1'b0, 0, 0, 1'b0, 500);
    run_frame(4, 1'b1, 1'b0, 0, 0, 1'b0, 600);
  endtask

  task automatic test_reset_midframe;
    int irqs;
    bit hit;
    repeat (8) @(posedge ACLK);
    obs_s.delete(); obs_w.delete();
    for (int i = 0; i < 8; i++) mem[i] = DW'(100 + i);
    @(posedge ACLK); #1;
    ctrl_log2n = 4'd3; ctrl_inverse = 1'b0; ctrl_start = 1'b1;
    @(posedge ACLK); #1;
    ctrl_start = 1'b0;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(posedge ACLK); #1;
      if (obs_s.size() >= 3) hit = 1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL midframe_reach: only %0d beats seen", obs_s.size()); end
    #1 ARESET = 1'b1;
    #1;
    total++;
    if (all_out !== 128'd0) begin bad++; $display("FAIL midframe_reset: got %h want 0", all_out); end
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    exp_frames = 0;
    irqs = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge ACLK); #1;
      if (irq) irqs++;
    end
    total++;
    if (irqs != 0 || sts_done !== 1'b0) begin
      bad++; $display("FAIL midframe_quiet: irqs %0d done %b want 0/0", irqs, sts_done);
    end
    run_frame(3, 1'b0, 1'b0, 0, 0, 1'b0, 200);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_illegal(2);
    test_illegal(11);
    test_tlast_errors();
    test_busy_start();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
